// File: rtl/mem_responder.sv
// Unified single-ported word memory serving instruction and data ports with wait states.
// Define MEM_RESP_ROUND_ROBIN_EN for round-robin arbitration instead of fixed data priority.
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int WC = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] WCNT = WC[3:0];

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic [31:0]   mem [DEPTH];

  logic          gnt_data;
  logic          acc_go;
  logic          acc_port;
  logic          acc_we;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic          mem_we;
  logic          unused_addr;

  assign unused_addr = ^{i_addr[31:AW+2], i_addr[1:0],
                         d_addr[31:AW+2], d_addr[1:0]};

`ifdef MEM_RESP_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  // on a tie, the port that lost last time wins
  assign gnt_data = d_req & (~i_req | ~last_d_q);
`else
  assign gnt_data = d_req;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    acc_go    = 1'b0;
    acc_port  = port_q;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
`ifdef MEM_RESP_ROUND_ROBIN_EN
    last_d_d  = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          port_d  = gnt_data;
          we_d    = gnt_data & d_we;
          idx_d   = gnt_data ? d_addr[AW+1:2] : i_addr[AW+1:2];
          wdata_d = d_wdata;
          cnt_d   = WCNT;
`ifdef MEM_RESP_ROUND_ROBIN_EN
          last_d_d = gnt_data;
`endif
          if (WAIT_STATES == 0) begin
            state_d   = RESP;
            acc_go    = 1'b1;
            acc_port  = port_d;
            acc_we    = we_d;
            acc_idx   = idx_d;
            acc_wdata = wdata_d;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          acc_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // the access happens on the edge that enters RESP
    if (acc_go) begin
      if (acc_port) begin
        d_ack_d   = 1'b1;
        d_rdata_d = acc_we ? acc_wdata : mem[acc_idx];
      end else begin
        i_ack_d   = 1'b1;
        i_rdata_d = mem[acc_idx];
      end
    end
  end

  assign mem_we = n_rst & acc_go & acc_port & acc_we;

  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
`ifdef MEM_RESP_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_RESP_ROUND_ROBIN_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
// Main instance uses two wait states; a second instance uses none.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 2;
`ifdef MEM_RESP_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;

  logic        s_i_req = 1'b0;
  logic [31:0] s_i_addr = 32'd0;
  logic [31:0] s_i_rdata;
  logic        s_i_ack;
  logic        s_d_req = 1'b0;
  logic        s_d_we = 1'b0;
  logic [31:0] s_d_addr = 32'd0;
  logic [31:0] s_d_wdata = 32'd0;
  logic [31:0] s_d_rdata;
  logic        s_d_ack;
  logic        s_busy;

  logic        z_i_req = 1'b0;
  logic [31:0] z_i_addr = 32'd0;
  logic [31:0] z_i_rdata;
  logic        z_i_ack;
  logic        z_d_req = 1'b0;
  logic        z_d_we = 1'b0;
  logic [31:0] z_d_addr = 32'd0;
  logic [31:0] z_d_wdata = 32'd0;
  logic [31:0] z_d_rdata;
  logic        z_d_ack;
  logic        z_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_ok  [DEPTH];
  bit          last_was_data = 1'b0;
  int          pool [8];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .i_req(s_i_req), .i_addr(s_i_addr),
    .i_rdata(s_i_rdata), .i_ack(s_i_ack),
    .d_req(s_d_req), .d_we(s_d_we),
    .d_addr(s_d_addr), .d_wdata(s_d_wdata),
    .d_rdata(s_d_rdata), .d_ack(s_d_ack),
    .busy(s_busy)
  );

  mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .n_rst(n_rst),
    .i_req(z_i_req), .i_addr(z_i_addr),
    .i_rdata(z_i_rdata), .i_ack(z_i_ack),
    .d_req(z_d_req), .d_we(z_d_we),
    .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_rdata(z_d_rdata), .d_ack(z_d_ack),
    .busy(z_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] mkaddr(input int idx);
    logic [31:0] a;
    logic [31:0] m;
    a = $urandom;
    m = 32'((DEPTH - 1) * 4);
    return (a & ~m) | 32'(idx * 4);
  endfunction

  task automatic run_txn(input bit di, input bit dd, input bit we,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd);
    int ni, nd, nmax;
    bit d_first;
    logic [31:0] ei, ed;
    bit ei_ok, ed_ok, eb;
    ni = -1; nd = -1;
    ei = 32'd0; ed = 32'd0; ei_ok = 0; ed_ok = 0;
    d_first = dd && (!di || !RR || !last_was_data);
    // data side of the model
    if (dd) nd = d_first ? WS : 2 * WS + 2;
    if (di) ni = (dd && d_first) ? 2 * WS + 2 : WS;
    if (dd && d_first) begin
      if (we) begin
        ref_mem[widx(da)] = wd; ref_ok[widx(da)] = 1;
        ed = wd; ed_ok = 1;
      end else begin
        ed = ref_mem[widx(da)]; ed_ok = ref_ok[widx(da)];
      end
      last_was_data = 1;
    end
    if (di) begin
      ei = ref_mem[widx(ia)]; ei_ok = ref_ok[widx(ia)];
      last_was_data = 0;
    end
    if (dd && !d_first) begin
      if (we) begin
        ref_mem[widx(da)] = wd; ref_ok[widx(da)] = 1;
        ed = wd; ed_ok = 1;
      end else begin
        ed = ref_mem[widx(da)]; ed_ok = ref_ok[widx(da)];
      end
      last_was_data = 1;
    end
    nmax = (ni > nd) ? ni : nd;
    s_i_req = di; s_i_addr = ia;
    s_d_req = dd; s_d_we = we; s_d_addr = da; s_d_wdata = wd;
    for (int n = 0; n <= nmax + 1; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("i_ack", 32'(s_i_ack), 32'(n == ni));
      check("d_ack", 32'(s_d_ack), 32'(n == nd));
      if (di && dd)
        eb = (n <= WS) || (n >= WS + 2 && n <= 2 * WS + 2);
      else
        eb = (n <= WS);
      check("busy", 32'(s_busy), 32'(eb));
      if (n == ni) begin
        if (ei_ok) check("i_rdata", s_i_rdata, ei);
        s_i_req = 0;
      end
      if (n == nd) begin
        if (ed_ok) check("d_rdata", s_d_rdata, ed);
        s_d_req = 0;
      end
      if (n == ni + 1 && ei_ok) check("i_rdata_hold", s_i_rdata, ei);
      if (n == nd + 1 && ed_ok) check("d_rdata_hold", s_d_rdata, ed);
    end
    s_i_req = 0;
    s_d_req = 0;
  endtask

  initial begin
    logic [31:0] zaddr [4];
    logic [31:0] zwd [4];
    bit          zwe [4];
    int          k, kind, ix, iy;
    logic [31:0] old;

    for (int i = 0; i < DEPTH; i++) ref_ok[i] = 0;
    for (int i = 0; i < 8; i++) pool[i] = (i * 37 + 5) % DEPTH;

    #1;
    check("rst_i_ack", 32'(s_i_ack), 32'd0);
    check("rst_d_ack", 32'(s_d_ack), 32'd0);
    check("rst_i_rdata", s_i_rdata, 32'd0);
    check("rst_d_rdata", s_d_rdata, 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    run_txn(0, 1, 1, 32'd0, 32'h0000_0010, 32'hDEAD_BEEF);
    run_txn(0, 1, 0, 32'd0, 32'h0000_0010, 32'd0);
    run_txn(0, 1, 1, 32'd0, 32'h0000_0020, 32'h1234_5678);
    run_txn(1, 0, 0, 32'h8000_0020, 32'd0, 32'd0);
    run_txn(1, 1, 0, 32'h8000_0020, 32'h0000_0010, 32'd0);
    run_txn(1, 1, 0, 32'h0000_0020, 32'h0000_0010, 32'd0);
    run_txn(0, 1, 1, 32'd0, 32'h0000_1004, 32'hA5A5_A5A5);
    run_txn(0, 1, 0, 32'd0, 32'h0000_0004, 32'd0);
    run_txn(0, 1, 0, 32'd0, 32'h0000_0006, 32'd0);
    run_txn(1, 0, 0, 32'h0000_1006, 32'd0, 32'd0);

    for (int i = 0; i < 8; i++)
      run_txn(0, 1, 1, 32'd0, mkaddr(pool[i]), $urandom);

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      ix = pool[$urandom_range(0, 7)];
      iy = pool[$urandom_range(0, 7)];
      run_txn(kind != 1, kind != 0, 1'($urandom_range(0, 1)),
              mkaddr(ix), mkaddr(iy), $urandom);
    end

    // write aborted by reset while waiting
    ix = pool[3];
    old = ref_mem[ix];
    s_d_req = 1; s_d_we = 1; s_d_addr = mkaddr(ix); s_d_wdata = ~old;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("abort_busy", 32'(s_busy), 32'd0);
    check("abort_d_ack", 32'(s_d_ack), 32'd0);
    check("abort_d_rdata", s_d_rdata, 32'd0);
    check("abort_i_rdata", s_i_rdata, 32'd0);
    s_d_req = 0;
    last_was_data = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("abort_no_ack", 32'(s_d_ack), 32'd0);
    end
    n_rst = 1'b1;
    @(negedge clk);
    run_txn(0, 1, 0, 32'd0, mkaddr(ix), 32'd0);
    run_txn(1, 0, 0, mkaddr(ix), 32'd0, 32'd0);

    // zero-wait instance, back-to-back with request held
    zaddr[0] = 32'h0; zwe[0] = 1; zwd[0] = 32'h1111_1111;
    zaddr[1] = 32'h4; zwe[1] = 1; zwd[1] = 32'h2222_2222;
    zaddr[2] = 32'h0; zwe[2] = 0; zwd[2] = 32'h0;
    zaddr[3] = 32'h4; zwe[3] = 0; zwd[3] = 32'h0;
    k = 0;
    z_d_req = 1; z_d_addr = zaddr[0]; z_d_we = zwe[0]; z_d_wdata = zwd[0];
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("z_ack", 32'(z_d_ack), 32'(n % 2 == 0));
      check("z_busy", 32'(z_busy), 32'(n % 2 == 0));
      if (n % 2 == 0) begin
        check("z_rdata", z_d_rdata, (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
        k++;
        if (k < 4) begin
          z_d_addr = zaddr[k]; z_d_we = zwe[k]; z_d_wdata = zwd[k];
        end else begin
          z_d_req = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
